// File: rtl/crtc_text_pixelizer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// crtc_text_pixelizer
//
// Purpose:
//   Text-mode pixel generator that sits behind a 6845-style CRTC. On each
//   character-clock enable it samples the CRTC address and timing signals. It
//   fetches the {attr,char} word from VRAM over a req/ack handshake, then reads
//   the glyph row from a synchronous font ROM. One character later it
//   serialises that glyph into 4-bit IRGB pixels on the pixel enable.
//
// Ports:
//   CLOCK, nRESET        system clock, synchronous active-low reset
//   CLKEN, PIXEN         character-clock enable and pixel enable
//   MA, RA               CRTC memory address and row address
//   DE, CURSOR           CRTC display enable and cursor
//   hsync_in, vsync_in   CRTC syncs
//   blink_en             1: attr[7] selects blink, 0: background intensity
//   border               IRGB colour shown while display enable is low
//   vram_req/addr/ack    VRAM fetch handshake
//   vram_data            {attr[15:8], char[7:0]}
//   rom_addr, rom_data   font ROM; data is valid one CLOCK after the address
//   pixel                IRGB output
//   de_out, hsync_out,
//   vsync_out            timing signals aligned with pixel
//   underrun             sticky flag: a fetch missed its character slot
//   underrun_clr         clears underrun (a new underrun event wins)
// -----------------------------------------------------------------------------
module crtc_text_pixelizer #(
  parameter int CHAR_W    = 8,
  parameter int FONT_RA_W = 3,
  parameter int ADDR_W    = 14
) (
  input  logic                   CLOCK,
  input  logic                   nRESET,
  input  logic                   CLKEN,
  input  logic                   PIXEN,
  input  logic [13:0]            MA,
  input  logic [4:0]             RA,
  input  logic                   DE,
  input  logic                   CURSOR,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   blink_en,
  input  logic [3:0]             border,
  output logic                   vram_req,
  output logic [ADDR_W-1:0]      vram_addr,
  input  logic                   vram_ack,
  input  logic [15:0]            vram_data,
  output logic [8+FONT_RA_W-1:0] rom_addr,
  input  logic [7:0]             rom_data,
  output logic [3:0]             pixel,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FONT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  fetch_state_t            r_state;
  logic                    r_vram_req;
  logic                    r_restart;
  logic [ADDR_W-1:0]       r_vram_addr;
  logic [8+FONT_RA_W-1:0]  r_rom_addr;
  logic [7:0]              r_attr;
  logic [7:0]              r_glyph;

  logic [FONT_RA_W-1:0]    r_s1_ra;
  logic                    r_s1_de;
  logic                    r_s1_cursor;
  logic                    r_s1_hs;
  logic                    r_s1_vs;

  logic [7:0]              r_s2_attr;
  logic                    r_s2_de;
  logic                    r_s2_hs;
  logic                    r_s2_vs;

  logic [CHAR_W-1:0]       r_shift;
  logic [3:0]              r_pixel;
  logic [4:0]              r_frame;
  logic                    r_vs_d;
  logic                    r_underrun;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  fetch_state_t            w_state_next;
  logic                    w_req_next;
  logic                    w_underrun_evt;
  logic                    w_ack_take;
  logic                    w_cur_valid;
  logic [7:0]              w_cur_attr;
  logic [7:0]              w_cur_glyph;
  logic [7:0]              w_eff_glyph;
  logic [CHAR_W-1:0]       w_load_vec;
  logic                    w_unused_ra;

  // Only the low row bits address the font.
  assign w_unused_ra = ^RA[4:FONT_RA_W];

  // A character slot ends while its fetch is still outstanding.
  assign w_underrun_evt = CLKEN && ((r_state == ST_WAIT) || (r_state == ST_FONT));

  // An ack is only honoured while the request is actually on the bus and the
  // slot is not ending in the same cycle.
  assign w_ack_take = (r_state == ST_WAIT) && r_vram_req && vram_ack && !CLKEN;

  // The fetched word is only usable once the glyph has landed; IDLE (DE low),
  // WAIT and FONT all present a blank character.
  assign w_cur_valid = (r_state == ST_DONE);
  assign w_cur_attr  = w_cur_valid ? r_attr  : 8'h00;
  assign w_cur_glyph = w_cur_valid ? r_glyph : 8'h00;

  // Cursor overrides blink, blink overrides the fetched glyph.
  always_comb begin
    w_eff_glyph = w_cur_glyph;
    if (r_s1_cursor && r_frame[3]) begin
      w_eff_glyph = 8'hFF;
    end else if (blink_en && w_cur_attr[7] && r_frame[4]) begin
      w_eff_glyph = 8'h00;
    end
  end

  // Map the 8-bit glyph MSB-first onto a CHAR_W-wide shift word.
  for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_load
    if (gi < 8) begin : g_bit
      assign w_load_vec[CHAR_W-1-gi] = w_eff_glyph[7-gi];
    end else begin : g_pad
      assign w_load_vec[CHAR_W-1-gi] = 1'b0;
    end
  end

  function automatic logic [3:0] f_colour(
    input logic       i_bit,
    input logic [7:0] i_attr,
    input logic       i_de,
    input logic       i_blink,
    input logic [3:0] i_border
  );
    logic [3:0] v_col;
    if (!i_de) begin
      v_col = i_border;
    end else if (i_bit) begin
      v_col = i_attr[3:0];
    end else if (i_blink) begin
      v_col = {1'b0, i_attr[6:4]};
    end else begin
      v_col = i_attr[7:4];
    end
    return v_col;
  endfunction

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state and request
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_vram_req;
    if (CLKEN) begin
      if (DE) begin
        w_state_next = ST_WAIT;
        // After an underrun the bus sees one idle cycle before the new request.
        w_req_next   = !w_underrun_evt;
      end else begin
        w_state_next = ST_IDLE;
        w_req_next   = 1'b0;
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_restart) begin
            w_req_next = 1'b1;
          end else if (w_ack_take) begin
            w_state_next = ST_FONT;
            w_req_next   = 1'b0;
          end
        end
        ST_FONT: w_state_next = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_state    <= ST_IDLE;
      r_vram_req <= 1'b0;
      r_restart  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_vram_req <= w_req_next;
      r_restart  <= CLKEN && DE && w_underrun_evt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: sampling, fetch capture, stage 2, pixel serialiser, frame count
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_vram_addr <= '0;
      r_rom_addr  <= '0;
      r_attr      <= 8'h00;
      r_glyph     <= 8'h00;
      r_s1_ra     <= '0;
      r_s1_de     <= 1'b0;
      r_s1_cursor <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s2_attr   <= 8'h00;
      r_s2_de     <= 1'b0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
      r_shift     <= '0;
      r_pixel     <= 4'h0;
      r_frame     <= 5'd0;
      r_vs_d      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_vs_d <= vsync_in;
      if (vsync_in && !r_vs_d) begin
        r_frame <= r_frame + 5'd1;
      end

      if (w_underrun_evt) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end

      if (CLKEN) begin
        // Stage 1: sample the CRTC for the character about to be fetched.
        r_s1_ra     <= RA[FONT_RA_W-1:0];
        r_s1_de     <= DE;
        r_s1_cursor <= CURSOR;
        r_s1_hs     <= hsync_in;
        r_s1_vs     <= vsync_in;
        if (DE) begin
          r_vram_addr <= MA[ADDR_W-1:0];
        end
        // Stage 2: retire the previous character into the output stage.
        r_s2_attr <= w_cur_attr;
        r_s2_de   <= r_s1_de;
        r_s2_hs   <= r_s1_hs;
        r_s2_vs   <= r_s1_vs;
      end

      if (w_ack_take) begin
        r_attr     <= vram_data[15:8];
        r_rom_addr <= {vram_data[7:0], r_s1_ra};
      end

      if ((r_state == ST_FONT) && !CLKEN) begin
        r_glyph <= rom_data;
      end

      if (PIXEN) begin
        if (CLKEN) begin
          // The load cycle already emits the glyph MSB with the new attribute.
          r_shift <= {w_load_vec[CHAR_W-2:0], 1'b0};
          r_pixel <= f_colour(w_load_vec[CHAR_W-1], w_cur_attr, r_s1_de,
                              blink_en, border);
        end else begin
          r_shift <= {r_shift[CHAR_W-2:0], 1'b0};
          r_pixel <= f_colour(r_shift[CHAR_W-1], r_s2_attr, r_s2_de,
                              blink_en, border);
        end
      end
    end
  end

  assign vram_req  = r_vram_req;
  assign vram_addr = r_vram_addr;
  assign rom_addr  = r_rom_addr;
  assign pixel     = r_pixel;
  assign de_out    = r_s2_de;
  assign hsync_out = r_s2_hs;
  assign vsync_out = r_s2_vs;
  assign underrun  = r_underrun;

endmodule
